// File: rtl/food_placer.sv
// -----------------------------------------------------------------------------
// food_placer
//   Turns the free-running 16-bit LFSR word into a free food cell on the snake
//   playfield. On request it samples random words, rejects candidates that are
//   off the board or occupied (checked through a 1-cycle-latency occupancy read
//   port) and reports either a placed cell or a failure after MAX_TRIES tries.
//
// Optional build macro: FOOD_SCAN_FALLBACK_EN
//   When defined, running out of random tries starts a row-major scan of the
//   whole board (x fastest, one cell per issue/check pair) instead of failing.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   rand_num    random word, new value every clk
//   place_req   request a new food cell (sampled only while idle)
//   occ_rd_en   occupancy read strobe
//   occ_x/occ_y occupancy read address (always the current candidate)
//   occ_data    occupied flag, valid the cycle after occ_rd_en
//   food_x/y    current food cell (holds last value while food_valid=0)
//   food_valid  food_x/food_y hold a placed food
//   busy        a search is in progress
//   place_done  1-cycle pulse, food placed
//   place_fail  1-cycle pulse, no free cell found
// -----------------------------------------------------------------------------
module food_placer #(
    parameter int GRID_W    = 32,
    parameter int GRID_H    = 24,
    parameter int X_BITS    = 5,
    parameter int Y_BITS    = 5,
    parameter int MAX_TRIES = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       rand_num,
    input  logic              place_req,
    output logic              occ_rd_en,
    output logic [X_BITS-1:0] occ_x,
    output logic [Y_BITS-1:0] occ_y,
    input  logic              occ_data,
    output logic [X_BITS-1:0] food_x,
    output logic [Y_BITS-1:0] food_y,
    output logic              food_valid,
    output logic              busy,
    output logic              place_done,
    output logic              place_fail
);
    localparam int TW = $clog2(MAX_TRIES) + 1;
    localparam logic [TW-1:0]   MAX_TRIES_L = TW'(MAX_TRIES);
    // One extra bit so that a grid as wide as the full coordinate range
    // still compares correctly.
    localparam logic [X_BITS:0] GRID_W_L = (X_BITS + 1)'(GRID_W);
    localparam logic [Y_BITS:0] GRID_H_L = (Y_BITS + 1)'(GRID_H);
`ifdef FOOD_SCAN_FALLBACK_EN
    localparam logic [X_BITS-1:0] LAST_X = X_BITS'(GRID_W - 1);
    localparam logic [Y_BITS-1:0] LAST_Y = Y_BITS'(GRID_H - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_CHECK  = 3'd3,
        ST_FAIL   = 3'd4
`ifdef FOOD_SCAN_FALLBACK_EN
        ,
        ST_SCAN_ISSUE = 3'd5,
        ST_SCAN_CHECK = 3'd6
`endif
    } state_t;

    state_t            state_reg, state_next;
    logic [TW-1:0]     tries_reg, tries_next, tries_inc;
    logic [X_BITS-1:0] cand_x_reg, cand_x_next;
    logic [Y_BITS-1:0] cand_y_reg, cand_y_next;
    logic [X_BITS-1:0] food_x_reg, food_x_next;
    logic [Y_BITS-1:0] food_y_reg, food_y_next;
    logic              food_valid_reg, food_valid_next;
    logic              place_done_reg, place_done_next;
    logic              exhausted;

    // Direct bit-field mapping of the random word; no modulo folding.
    logic [X_BITS-1:0] rand_x;
    logic [Y_BITS-1:0] rand_y;
    logic              rand_in_range;
    assign rand_x        = rand_num[X_BITS-1:0];
    assign rand_y        = rand_num[X_BITS+Y_BITS-1:X_BITS];
    assign rand_in_range = ({1'b0, rand_x} < GRID_W_L) && ({1'b0, rand_y} < GRID_H_L);

    // Upper random bits beyond the coordinate fields are deliberately ignored.
    logic unused_rand_bits;
    assign unused_rand_bits = ^rand_num;

    assign tries_inc = tries_reg + 1'b1;

    always_comb begin
        state_next      = state_reg;
        tries_next      = tries_reg;
        cand_x_next     = cand_x_reg;
        cand_y_next     = cand_y_reg;
        food_x_next     = food_x_reg;
        food_y_next     = food_y_reg;
        food_valid_next = food_valid_reg;
        place_done_next = 1'b0;
        exhausted       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (place_req) begin
                    food_valid_next = 1'b0;
                    tries_next      = '0;
                    state_next      = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (rand_in_range) begin
                    cand_x_next = rand_x;
                    cand_y_next = rand_y;
                    state_next  = ST_ISSUE;
                end else begin
                    tries_next = tries_inc;
                    exhausted  = (tries_inc == MAX_TRIES_L);
                end
            end
            ST_ISSUE: begin
                state_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (!occ_data) begin
                    food_x_next     = cand_x_reg;
                    food_y_next     = cand_y_reg;
                    food_valid_next = 1'b1;
                    place_done_next = 1'b1;
                    state_next      = ST_IDLE;
                end else begin
                    tries_next = tries_inc;
                    exhausted  = (tries_inc == MAX_TRIES_L);
                    state_next = ST_SAMPLE;
                end
            end
            ST_FAIL: begin
                state_next = ST_IDLE;
            end
`ifdef FOOD_SCAN_FALLBACK_EN
            ST_SCAN_ISSUE: begin
                state_next = ST_SCAN_CHECK;
            end
            ST_SCAN_CHECK: begin
                if (!occ_data) begin
                    food_x_next     = cand_x_reg;
                    food_y_next     = cand_y_reg;
                    food_valid_next = 1'b1;
                    place_done_next = 1'b1;
                    state_next      = ST_IDLE;
                end else if (cand_x_reg != LAST_X) begin
                    cand_x_next = cand_x_reg + 1'b1;
                    state_next  = ST_SCAN_ISSUE;
                end else if (cand_y_reg != LAST_Y) begin
                    cand_x_next = '0;
                    cand_y_next = cand_y_reg + 1'b1;
                    state_next  = ST_SCAN_ISSUE;
                end else begin
                    state_next = ST_FAIL;
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Random attempts used up: fall back to the board scan when built
        // in, otherwise report failure.
        if (exhausted) begin
`ifdef FOOD_SCAN_FALLBACK_EN
            cand_x_next = '0;
            cand_y_next = '0;
            state_next  = ST_SCAN_ISSUE;
`else
            state_next  = ST_FAIL;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            tries_reg      <= '0;
            cand_x_reg     <= '0;
            cand_y_reg     <= '0;
            food_x_reg     <= '0;
            food_y_reg     <= '0;
            food_valid_reg <= 1'b0;
            place_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            tries_reg      <= tries_next;
            cand_x_reg     <= cand_x_next;
            cand_y_reg     <= cand_y_next;
            food_x_reg     <= food_x_next;
            food_y_reg     <= food_y_next;
            food_valid_reg <= food_valid_next;
            place_done_reg <= place_done_next;
        end
    end

`ifdef FOOD_SCAN_FALLBACK_EN
    assign occ_rd_en = (state_reg == ST_ISSUE) || (state_reg == ST_SCAN_ISSUE);
`else
    assign occ_rd_en = (state_reg == ST_ISSUE);
`endif
    assign occ_x      = cand_x_reg;
    assign occ_y      = cand_y_reg;
    assign food_x     = food_x_reg;
    assign food_y     = food_y_reg;
    assign food_valid = food_valid_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign place_done = place_done_reg;
    assign place_fail = (state_reg == ST_FAIL);

endmodule

// File: tb/tb_food_placer.sv
// -----------------------------------------------------------------------------
// tb_food_placer
//   Self-checking bench for food_placer. A per-cycle table of random words and
//   an occupancy map drive the DUT; a timing-level model predicts, for each
//   search, when and with which cell (or failure) the search completes.
// -----------------------------------------------------------------------------
module tb_food_placer;
    localparam int GW  = 32;
    localparam int GH  = 24;
    localparam int XB  = 5;
    localparam int YB  = 5;
    localparam int MT  = 64;
    localparam int SEQ = 1024;

    logic          clk;
    logic          reset_n;
    logic [15:0]   rand_num;
    logic          place_req;
    logic          occ_rd_en;
    logic [XB-1:0] occ_x;
    logic [YB-1:0] occ_y;
    logic          occ_data;
    logic [XB-1:0] food_x;
    logic [YB-1:0] food_y;
    logic          food_valid;
    logic          busy;
    logic          place_done;
    logic          place_fail;

    food_placer #(
        .GRID_W    (GW),
        .GRID_H    (GH),
        .X_BITS    (XB),
        .Y_BITS    (YB),
        .MAX_TRIES (MT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rand_num   (rand_num),
        .place_req  (place_req),
        .occ_rd_en  (occ_rd_en),
        .occ_x      (occ_x),
        .occ_y      (occ_y),
        .occ_data   (occ_data),
        .food_x     (food_x),
        .food_y     (food_y),
        .food_valid (food_valid),
        .busy       (busy),
        .place_done (place_done),
        .place_fail (place_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_assert;
    int          n_fail;
    int          cyc;
    logic [15:0] rand_seq [SEQ];
    bit          occ_map  [GH][GW];
    int          exp_fx;
    int          exp_fy;
    logic        rd_pend;
    logic [XB-1:0] rd_x;
    logic [YB-1:0] rd_y;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    function automatic bit occ_lookup(input int x, input int y);
        if (x < GW && y < GH) return occ_map[y][x];
        return 1'b1;
    endfunction

    // Cycle c runs from posedge c to posedge c+1; rand_num holds rand_seq[c].
    initial begin
        cyc      = 0;
        rand_num = 16'h0;
        occ_data = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            rand_num = rand_seq[cyc % SEQ];
            occ_data = rd_pend ? occ_lookup(int'(rd_x), int'(rd_y)) : 1'($urandom);
        end
    end

    initial begin
        rd_pend = 1'b0;
        rd_x    = '0;
        rd_y    = '0;
        forever begin
            @(negedge clk);
            rd_pend = occ_rd_en;
            rd_x    = occ_x;
            rd_y    = occ_y;
        end
    end

    // Timing model: the search samples its first word in cycle t0. A word
    // off the board costs 1 cycle, an occupied cell 3 cycles; a free cell is
    // reported 3 cycles after its sample. After MT attempts the search fails
    // in the next cycle (or scans the board, 2 cycles per cell).
    function automatic void predict(input int t0, output bit ok, output int r,
                                    output int fx, output int fy, output int nrd);
        int t, tries, w, cx, cy;
        t = t0; tries = 0; nrd = 0; ok = 1'b0; fx = 0; fy = 0; r = 0;
        while (tries < MT) begin
            w  = int'(rand_seq[t % SEQ]);
            cx = w % 32;
            cy = (w / 32) % 32;
            if (cx >= GW || cy >= GH) begin
                tries++;
                t += 1;
            end else begin
                nrd++;
                if (!occ_map[cy][cx]) begin
                    ok = 1'b1; fx = cx; fy = cy; r = t + 3;
                    return;
                end
                tries++;
                t += 3;
            end
        end
`ifdef FOOD_SCAN_FALLBACK_EN
        for (int k = 0; k < GW * GH; k++) begin
            nrd++;
            if (!occ_map[k / GW][k % GW]) begin
                ok = 1'b1; fx = k % GW; fy = k / GW; r = t + 2 * k + 2;
                return;
            end
        end
        t += 2 * GW * GH;
`endif
        r = t;
    endfunction

    // Raises place_req in the current cycle and checks every cycle until the
    // DUT is idle again. Returns the cycles where done/fail were observed.
    task automatic search(input bit keep_req, output int done_cyc, output int fail_cyc);
        int n, r, fx, fy, nrd_exp, nrd, e;
        bit ok;
        bit fin;
        n = cyc;
        place_req = 1'b1;
        predict(n + 1, ok, r, fx, fy, nrd_exp);
        e = ok ? r : r + 1;
        done_cyc = -1;
        fail_cyc = -1;
        nrd = 0;
        for (int c = n + 1; c <= e; c++) begin
            @(posedge clk);
            #1;
            if (!keep_req) place_req = 1'b0;
            @(negedge clk);
            fin = ok && (c >= r);
            chk("busy",       32'(busy),       32'(ok ? (c < r) : (c <= r)));
            chk("place_done", 32'(place_done), 32'(ok && c == r));
            chk("place_fail", 32'(place_fail), 32'(!ok && c == r));
            chk("food_valid", 32'(food_valid), 32'(fin));
            chk("food_x",     32'(food_x),     32'(fin ? fx : exp_fx));
            chk("food_y",     32'(food_y),     32'(fin ? fy : exp_fy));
            if (occ_rd_en === 1'b1) begin
                nrd++;
                chk("occ_in_range", 32'(int'(occ_x) < GW && int'(occ_y) < GH), 32'd1);
            end
            if (place_done === 1'b1 && done_cyc < 0) done_cyc = c;
            if (place_fail === 1'b1 && fail_cyc < 0) fail_cyc = c;
        end
        chk("occ_reads", 32'(nrd), 32'(nrd_exp));
        if (ok) begin
            exp_fx = fx;
            exp_fy = fy;
        end
        $display("search req@%0d: %s at cycle %0d, food=(%0d,%0d), %0d occupancy reads",
                 n, ok ? "placed" : "no free cell", r, exp_fx, exp_fy, nrd);
    endtask

    task automatic zero_chk(input string tag);
        chk({tag, "_busy"},       32'(busy),       32'd0);
        chk({tag, "_occ_rd_en"},  32'(occ_rd_en),  32'd0);
        chk({tag, "_place_done"}, 32'(place_done), 32'd0);
        chk({tag, "_place_fail"}, 32'(place_fail), 32'd0);
        chk({tag, "_food_valid"}, 32'(food_valid), 32'd0);
        chk({tag, "_food_x"},     32'(food_x),     32'd0);
        chk({tag, "_food_y"},     32'(food_y),     32'd0);
    endtask

    task automatic fill_map(input int pct_occupied);
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++)
                occ_map[y][x] = ($urandom_range(99) < pct_occupied);
    endtask

    initial begin
        int n, d, f;
        n_assert  = 0;
        n_fail    = 0;
        place_req = 1'b0;
        reset_n   = 1'b0;
        exp_fx    = 0;
        exp_fy    = 0;
        for (int i = 0; i < SEQ; i++) rand_seq[i] = 16'($urandom);
        fill_map(0);

        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        zero_chk("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // First-try success: (3,9) free
        n = cyc;
        rand_seq[(n + 1) % SEQ] = 16'h0123;
        search(1'b0, d, f);
        chk("first_try_latency", 32'(d - n), 32'd4);
        chk("first_try_x", 32'(food_x), 32'd3);
        chk("first_try_y", 32'(food_y), 32'd9);

        // Two off-board words (y=25) then (3,9)
        n = cyc;
        rand_seq[(n + 1) % SEQ] = 16'h0322;
        rand_seq[(n + 2) % SEQ] = 16'h0322;
        rand_seq[(n + 3) % SEQ] = 16'h0123;
        search(1'b0, d, f);
        chk("range_rej_latency", 32'(d - n), 32'd6);
        chk("range_rej_x", 32'(food_x), 32'd3);

        // (3,9) occupied, then (5,2) free
        n = cyc;
        occ_map[9][3] = 1'b1;
        rand_seq[(n + 1) % SEQ] = 16'h0123;
        rand_seq[(n + 4) % SEQ] = 16'h0045;
        search(1'b0, d, f);
        chk("occ_rej_latency", 32'(d - n), 32'd7);
        chk("occ_rej_x", 32'(food_x), 32'd5);
        chk("occ_rej_y", 32'(food_y), 32'd2);
        occ_map[9][3] = 1'b0;

        // Exhaustion: whole board occupied, every word lands on (0,0)
        fill_map(100);
        for (int i = 0; i < SEQ; i++) rand_seq[i] = 16'h0000;
        n = cyc;
        search(1'b0, d, f);
        chk("exh_no_done", 32'(d), 32'(-1));
`ifdef FOOD_SCAN_FALLBACK_EN
        chk("exh_fail_latency", 32'(f - n), 32'(1 + 3 * MT + 2 * GW * GH));
`else
        chk("exh_fail_latency", 32'(f - n), 32'(1 + 3 * MT));
`endif

        // Exhaustion with only (7,0) free
        occ_map[0][7] = 1'b0;
        n = cyc;
        search(1'b0, d, f);
`ifdef FOOD_SCAN_FALLBACK_EN
        chk("scan_latency", 32'(d - n), 32'(1 + 3 * MT + 16));
        chk("scan_x", 32'(food_x), 32'd7);
        chk("scan_y", 32'(food_y), 32'd0);
`else
        chk("exh2_fail_latency", 32'(f - n), 32'(1 + 3 * MT));
`endif

        // place_req held through a search: one search, next only from IDLE
        for (int i = 0; i < SEQ; i++) rand_seq[i] = 16'($urandom);
        fill_map(30);
        search(1'b1, d, f);
        search(1'b0, d, f);

        // Random searches on a partly occupied board
        for (int k = 0; k < 6; k++) begin
            fill_map(20 + 10 * k);
            search(1'b0, d, f);
        end

        // Reset asserted while the DUT is in CHECK
        fill_map(0);
        n = cyc;
        rand_seq[(n + 1) % SEQ] = 16'h0123;
        place_req = 1'b1;
        @(posedge clk);
        #1;
        place_req = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_issue_rd_en", 32'(occ_rd_en), 32'd1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        zero_chk("mid_reset");
        @(posedge clk);
        #1;
        zero_chk("mid_reset_hold");
        @(negedge clk);
        reset_n = 1'b1;
        exp_fx  = 0;
        exp_fy  = 0;
        n = cyc;
        rand_seq[(n + 1) % SEQ] = 16'h0045;
        search(1'b0, d, f);
        chk("post_reset_latency", 32'(d - n), 32'd4);
        chk("post_reset_x", 32'(food_x), 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
